// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit bridging the MEM stage to a req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_next;
    logic        we_q, mis_q, mis, in_b, in_h, q_b, q_h;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, sh, ld;
    logic [1:0]  off;
    logic [3:0]  strb;

    assign in_b = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b100);
    assign in_h = (req_funct3_i == 3'b001) || (req_funct3_i == 3'b101);
    assign q_b  = (f3_q == 3'b000) || (f3_q == 3'b100);
    assign q_h  = (f3_q == 3'b001) || (f3_q == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis        = (in_h & req_addr_i[0]) | (~in_b & ~in_h & |req_addr_i[1:0]);
    assign misalign_o = (state == DONE) & mis_q;
`else
    assign mis        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Effective offset already aligned down to the access size
    assign off  = q_b ? addr_q[1:0] : q_h ? {addr_q[1], 1'b0} : 2'b00;
    assign strb = q_b ? (4'b0001 << off) : q_h ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign sh   = bus_rdata_i >> {off, 3'b000};
    assign ld   = q_b ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]}
                : q_h ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;

    assign stall_o       = ((state == IDLE) & req_valid_i) | (state == REQ) | (state == WAIT);
    assign rdata_valid_o = (state == DONE) & ~we_q & ~mis_q;
    assign bus_req_o     = (state == REQ);
    assign bus_we_o      = (state == REQ) & we_q;
    assign bus_wstrb_o   = (state == REQ) & we_q ? strb : 4'b0000;
    assign bus_addr_o    = {addr_q[31:2], 2'b00};
    assign bus_wdata_o   = q_b ? {4{wdata_q[7:0]}} : q_h ? {2{wdata_q[15:0]}} : wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_o <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                mis_q   <= mis;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (state == WAIT && bus_rvalid_i)
                rdata_o <= ld;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid_i) state_next = mis ? DONE : REQ;
            REQ:     if (bus_gnt_i) state_next = we_q ? DONE : WAIT;
            WAIT:    if (bus_rvalid_i) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule
